// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: PC handshake, instruction-memory req/ack and decode valid/ready.
// The master modport is the fetch unit; the slave modport is its environment.
interface inst_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              pc_accept;
  logic              flush;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              if_fault;

  modport master (
    input  pc, pc_valid, flush, imem_ack, imem_rdata, if_ready,
    output pc_accept, imem_req, imem_addr, if_valid, if_instr, if_pc, if_fault
  );

  modport slave (
    output pc, pc_valid, flush, imem_ack, imem_rdata, if_ready,
    input  pc_accept, imem_req, imem_addr, if_valid, if_instr, if_pc, if_fault
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: takes one pc, runs a single req/ack to instruction memory and
// holds the returned word for decode; flushes drop anything in flight or held.
module inst_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  inst_fetch_if.master bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e            state_q;
  logic              imem_req_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic              if_valid_q;
  logic [DATA_W-1:0] if_instr_q;
  logic [ADDR_W-1:0] if_pc_q;
  logic              if_fault_q;
  logic              accept_s;
  logic              pc_aligned_s;

  // A pc is taken from IDLE, or from HOLD in the same cycle decode consumes the held word.
  always_comb begin
    accept_s = 1'b0;
    if (bus.pc_valid && !bus.flush) begin
      if (state_q == IDLE) begin
        accept_s = 1'b1;
      end else if ((state_q == HOLD) && bus.if_ready) begin
        accept_s = 1'b1;
      end else begin
        accept_s = 1'b0;
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  assign pc_aligned_s = (bus.pc[1:0] == 2'b00);

  // Fetch sequencer; accept overrides the per-state transitions since it only fires from IDLE/HOLD.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= {ADDR_W{1'b0}};
      if_valid_q  <= 1'b0;
      if_instr_q  <= {DATA_W{1'b0}};
      if_pc_q     <= {ADDR_W{1'b0}};
      if_fault_q  <= 1'b0;
    end else if (accept_s) begin
      if_pc_q <= bus.pc;
      if (pc_aligned_s) begin
        imem_addr_q <= {bus.pc[ADDR_W-1:2], 2'b00};
        imem_req_q  <= 1'b1;
        if_valid_q  <= 1'b0;
        state_q     <= REQ;
      end else begin
        if_instr_q <= NOP_WORD;
        if_fault_q <= 1'b1;
        if_valid_q <= 1'b1;
        state_q    <= HOLD;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= IDLE;
        end
        REQ: begin
          if (bus.imem_ack) begin
            imem_req_q <= 1'b0;
            if (bus.flush) begin
              state_q <= IDLE;
            end else begin
              if_instr_q <= bus.imem_rdata;
              if_fault_q <= 1'b0;
              if_valid_q <= 1'b1;
              state_q    <= HOLD;
            end
          end else if (bus.flush) begin
            // The memory cannot be told to abandon a request, so wait out its ack.
            state_q <= DRAIN;
          end else begin
            state_q <= REQ;
          end
        end
        DRAIN: begin
          if (bus.imem_ack) begin
            imem_req_q <= 1'b0;
            state_q    <= IDLE;
          end else begin
            state_q <= DRAIN;
          end
        end
        HOLD: begin
          if (bus.flush || bus.if_ready) begin
            if_valid_q <= 1'b0;
            state_q    <= IDLE;
          end else begin
            state_q <= HOLD;
          end
        end
        default: begin
          imem_req_q <= 1'b0;
          if_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.pc_accept = accept_s;
  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = imem_addr_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_fault  = if_fault_q;
endmodule
